jt12_wr_seq: RTL and testbench

JT12_WR_SEQ -- requirements
Module: jt12_wr_seq

---
 rtl/jt12_pkg.sv | 56 +++++
 rtl/jt12_cmd_fifo.sv | 55 +++++
 rtl/jt12_wr_seq.sv | 150 +++++++++++++++
 tb/tb_jt12_wr_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_pkg.sv
// Shared types and register map for the JT12 write sequencer.
package jt12_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_GAP    = 3'd2,
    ST_DATA   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_WAIT   = 3'd5
  } wr_state_t;

  localparam int CMD_W = 17;

  typedef struct packed {
    logic       port;
    logic [7:0] regn;
    logic [7:0] data;
  } cmd_t;

  // Global (port 0 only) register block
  localparam logic [7:0] REG_LFO        = 8'h22;
  localparam logic [7:0] REG_TIMER_A_HI = 8'h24;
  localparam logic [7:0] REG_TIMER_A_LO = 8'h25;
  localparam logic [7:0] REG_TIMER_B    = 8'h26;
  localparam logic [7:0] REG_TIMER_CTL  = 8'h27;
  localparam logic [7:0] REG_KEY_ON     = 8'h28;
  localparam logic [7:0] REG_DAC_DATA   = 8'h2A;
  localparam logic [7:0] REG_DAC_EN     = 8'h2B;
  localparam logic [7:0] REG_GLOBAL_LO  = 8'h22;
  localparam logic [7:0] REG_GLOBAL_HI  = 8'h2F;

  // Per-channel block
  localparam logic [7:0] REG_FNUM_LO    = 8'hA0;
  localparam logic [7:0] REG_FNUM_HI    = 8'hA4;
  localparam logic [7:0] REG_FB_ALG     = 8'hB0;
  localparam logic [7:0] REG_PAN_AMS    = 8'hB4;
  localparam logic [7:0] REG_CH_LO      = 8'hA0;
  localparam logic [7:0] REG_CH_HI      = 8'hB6;

  function automatic logic is_global_reg(input logic [7:0] r);
    return (r >= REG_GLOBAL_LO) && (r <= REG_GLOBAL_HI);
  endfunction

  function automatic logic is_chan_reg(input logic [7:0] r);
    return (r >= REG_CH_LO) && (r <= REG_CH_HI);
  endfunction

  function automatic logic is_named_reg(input logic [7:0] r);
    return (r == REG_LFO) || (r == REG_TIMER_A_HI) || (r == REG_TIMER_A_LO) ||
           (r == REG_TIMER_B) || (r == REG_TIMER_CTL) || (r == REG_KEY_ON) ||
           (r == REG_DAC_DATA) || (r == REG_DAC_EN) || (r == REG_FNUM_LO) ||
           (r == REG_FNUM_HI) || (r == REG_FB_ALG) || (r == REG_PAN_AMS);
  endfunction

endpackage

// File: rtl/jt12_cmd_fifo.sv
// Command FIFO: read pointer, write pointer and occupancy count; head is read combinationally.
module jt12_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push at full is only taken when the same edge frees a slot.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jt12_wr_seq.sv
// Queues register writes and plays them to the JT12 bus as address strobe, gap, data strobe, then busy wait.
module jt12_wr_seq
  import jt12_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_port,
  input  logic [7:0]                    cmd_reg,
  input  logic [7:0]                    cmd_data,
  output logic [7:0]                    ym_din,
  output logic [1:0]                    ym_addr,
  output logic                          ym_write,
  input  logic                          ym_busy,
  output logic                          idle,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          timeout_err
);

  localparam logic [2:0] GAP_LOAD = 3'(GAP - 1);
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

  logic [1:0]       rst_sync;
  logic             rst_i_n;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_dout;

  wr_state_t        state, state_d;
  cmd_t             hold, hold_d;
  logic [2:0]       gap_cnt, gap_d;
  logic [7:0]       tmo_cnt, tmo_d;
  logic             err_d;
  logic             wr_d;
  logic [1:0]       addr_d;
  logic [7:0]       din_d;

  // Assert asynchronously, release on a clean clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign idle      = fifo_empty && (state == ST_IDLE);

  jt12_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_i_n),
    .push  (fifo_push),
    .din   ({cmd_port, cmd_reg, cmd_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state       <= ST_IDLE;
      hold        <= '0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
      ym_write    <= 1'b0;
      ym_addr     <= '0;
      ym_din      <= '0;
    end else begin
      state       <= state_d;
      hold        <= hold_d;
      gap_cnt     <= gap_d;
      tmo_cnt     <= tmo_d;
      timeout_err <= err_d;
      ym_write    <= wr_d;
      ym_addr     <= addr_d;
      ym_din      <= din_d;
    end
  end

  // Bus outputs are registered from the current state, so each strobe trails its state by one clock.
  always_comb begin
    state_d  = state;
    hold_d   = hold;
    gap_d    = gap_cnt;
    tmo_d    = tmo_cnt;
    err_d    = timeout_err;
    fifo_pop = 1'b0;
    wr_d     = 1'b0;
    addr_d   = ym_addr;
    din_d    = ym_din;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = cmd_t'(fifo_dout);
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        wr_d    = 1'b1;
        addr_d  = {hold.port, 1'b0};
        din_d   = hold.regn;
        gap_d   = GAP_LOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == 3'd0) state_d = ST_DATA;
        else                 gap_d   = gap_cnt - 1'b1;
      end
      ST_DATA: begin
        wr_d    = 1'b1;
        addr_d  = {hold.port, 1'b1};
        din_d   = hold.data;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        tmo_d   = TMO_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Terminal count is the edge on which the counter would reach zero.
        if (!ym_busy) begin
          state_d = ST_IDLE;
        end else if (tmo_cnt <= 8'd1) begin
          tmo_d   = 8'd0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d   = tmo_cnt - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jt12_wr_seq.sv
// Self-checking bench for jt12_wr_seq: directed vector table, multi-cycle corner sequences, random stream.
module tb_jt12_wr_seq;

  localparam int DEPTH = 4;
  localparam int GAP_C = 2;
  localparam int TMO   = 255;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_port;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic [7:0] ym_din;
  logic [1:0] ym_addr;
  logic       ym_write;
  logic       ym_busy;
  logic       idle;
  logic [2:0] level;
  logic       timeout_err;

  int tests;
  int fails;
  int n_addr;
  int n_data;
  int busy_len;
  int busy_cnt;
  bit busy_force;
  logic [16:0] sb_q[$];

  jt12_wr_seq #(
    .FIFO_DEPTH (DEPTH),
    .GAP        (GAP_C),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_port    (cmd_port),
    .cmd_reg     (cmd_reg),
    .cmd_data    (cmd_data),
    .ym_din      (ym_din),
    .ym_addr     (ym_addr),
    .ym_write    (ym_write),
    .ym_busy     (ym_busy),
    .idle        (idle),
    .level       (level),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic p, input logic [7:0] r, input logic [7:0] d);
    int n;
    n = 0;
    cmd_port  = p;
    cmd_reg   = r;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!cmd_ready) begin
      fails++;
      $display("FAIL send_accept: cmd_ready low for %0d cycles, expected high", n);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb_q.push_back({p, r, d});
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_strobe(input logic a0, input int limit, output int n);
    n = 0;
    while (!(ym_write && ym_addr[0] == a0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      tests++;
      fails++;
      $display("FAIL wait_strobe: no strobe with A0=%0d within %0d cycles", a0, limit);
    end
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!idle && n < limit);
    if (!idle) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: idle still low after %0d cycles", limit);
    end
  endtask

  // Chip busy model: busy rises with the data strobe and stays up busy_len cycles.
  initial begin : busy_model
    logic prev;
    prev     = 1'b0;
    busy_cnt = 0;
    ym_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (ym_write && ym_addr[0] && !prev) busy_cnt = busy_len;
      else if (busy_cnt > 0)              busy_cnt--;
      prev    = ym_write;
      ym_busy = busy_force || (busy_cnt != 0);
    end
  end

  // Receive model: edge-detects ym_write, pairs address and data writes, compares against the scoreboard.
  initial begin : monitor
    logic        prev;
    logic        pend;
    int          low_cnt;
    logic [1:0]  pa;
    logic [7:0]  preg;
    logic [16:0] e;
    prev    = 1'b0;
    pend    = 1'b0;
    low_cnt = 100;
    pa      = '0;
    preg    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev    = 1'b0;
        pend    = 1'b0;
        low_cnt = 100;
        sb_q.delete();
      end else begin
        if (ym_write) begin
          check("mon_strobe_width", prev, 1'b0);
          if (!prev) begin
            if (!ym_addr[0]) begin
              n_addr++;
              check("mon_addr_unpaired", pend, 1'b0);
              check("mon_low_between", low_cnt >= 2, 1'b1);
              pend = 1'b1;
              pa   = ym_addr;
              preg = ym_din;
            end else begin
              n_data++;
              check("mon_data_paired", pend, 1'b1);
              check("mon_gap_len", low_cnt, GAP_C);
              check("mon_data_port", ym_addr[1], pa[1]);
              tests++;
              if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL mon_scoreboard: data write %0h/%0h with nothing expected", preg, ym_din);
              end else begin
                e = sb_q.pop_front();
                if ({pa[1], preg, ym_din} !== e) begin
                  fails++;
                  $display("FAIL mon_scoreboard: got %0h, expected %0h", {pa[1], preg, ym_din}, e);
                end
              end
              pend = 1'b0;
            end
            low_cnt = 0;
          end
        end else begin
          low_cnt++;
        end
        prev = ym_write;
      end
    end
  end

  typedef struct {
    logic       p;
    logic [7:0] r;
    logic [7:0] d;
    int         busy;
    logic [1:0] exp_aa;
    logic [7:0] exp_da;
    logic [1:0] exp_ad;
    logic [7:0] exp_dd;
    int         exp_idle;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n;
    int base_a;
    int base_d;
    tests      = 0;
    fails      = 0;
    n_addr     = 0;
    n_data     = 0;
    busy_len   = 0;
    busy_force = 1'b0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_port   = 1'b0;
    cmd_reg    = 8'h00;
    cmd_data   = 8'h00;

    // p, reg, data, busy cycles, addr/din on address strobe, addr/din on data strobe, data-to-idle cycles
    vt[0] = '{1'b0, 8'h28, 8'hF1, 10, 2'd0, 8'h28, 2'd1, 8'hF1, 11};
    vt[1] = '{1'b1, 8'hA4, 8'h22,  3, 2'd2, 8'hA4, 2'd3, 8'h22,  4};
    vt[2] = '{1'b0, 8'h30, 8'h71,  0, 2'd0, 8'h30, 2'd1, 8'h71,  2};
    vt[3] = '{1'b1, 8'hB6, 8'hC0,  1, 2'd2, 8'hB6, 2'd3, 8'hC0,  2};
    vt[4] = '{1'b0, 8'h22, 8'h00,  2, 2'd0, 8'h22, 2'd1, 8'h00,  3};
    vt[5] = '{1'b1, 8'h2F, 8'hFF,  4, 2'd2, 8'h2F, 2'd3, 8'hFF,  5};

    repeat (3) @(negedge clk);
    check("rst_ym_write", ym_write, 1'b0);
    check("rst_ym_addr", ym_addr, 2'd0);
    check("rst_ym_din", ym_din, 8'h00);
    check("rst_idle", idle, 1'b1);
    check("rst_level", level, 3'd0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_timeout_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", idle, 1'b1);

    for (int i = 0; i < 6; i++) begin
      busy_len = vt[i].busy;
      send(vt[i].p, vt[i].r, vt[i].d);
      check("acc_idle_low", idle, 1'b0);
      check("acc_level", level, 3'd1);
      wait_strobe(1'b0, 20, n);
      check("latency_to_addr", n, 2);
      check("addr_strobe_addr", ym_addr, vt[i].exp_aa);
      check("addr_strobe_din", ym_din, vt[i].exp_da);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ym_write && n < 20);
      check("addr_to_data", n, GAP_C + 1);
      check("data_strobe_addr", ym_addr, vt[i].exp_ad);
      check("data_strobe_din", ym_din, vt[i].exp_dd);
      wait_idle(400, n);
      check("data_to_idle", n, vt[i].exp_idle);
      check("no_timeout", timeout_err, 1'b0);
    end

    // Full FIFO: hold the FSM in WAIT, fill four entries, fifth waits for the first pop.
    busy_len   = 0;
    busy_force = 1'b1;
    base_d     = n_data;
    repeat (2) @(negedge clk);
    send(1'b0, 8'h30, 8'h11);
    wait_strobe(1'b1, 20, n);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) send(1'b0, 8'h40 + 8'(k), 8'h50 + 8'(k));
    check("full_cmd_ready", cmd_ready, 1'b0);
    check("full_level", level, 3'd4);
    fork
      send(1'b1, 8'hB5, 8'h55);
      begin
        repeat (6) @(negedge clk);
        check("full_still_blocked", cmd_ready, 1'b0);
        busy_force = 1'b0;
      end
    join
    wait_idle(500, n);
    check("full_all_written", n_data - base_d, 6);
    check("full_no_timeout", timeout_err, 1'b0);

    // Busy stuck high: WAIT gives up after TIMEOUT cycles and the next command still runs.
    busy_force = 1'b1;
    repeat (3) @(negedge clk);
    send(1'b0, 8'h2B, 8'h80);
    wait_strobe(1'b1, 20, n);
    check("tmo_before", timeout_err, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout_err && n < 400);
    check("tmo_cycles", n, 256);
    check("tmo_idle", idle, 1'b1);
    busy_force = 1'b0;
    busy_len   = 1;
    repeat (3) @(negedge clk);
    send(1'b1, 8'hB4, 8'hC0);
    wait_strobe(1'b1, 20, n);
    check("tmo_next_addr", ym_addr, 2'd3);
    check("tmo_next_din", ym_din, 8'hC0);
    wait_idle(400, n);
    check("tmo_sticky", timeout_err, 1'b1);

    // Reset while the address strobe is on the bus with a second command queued.
    busy_len = 2;
    send(1'b0, 8'h28, 8'h01);
    send(1'b0, 8'h28, 8'h02);
    wait_strobe(1'b0, 20, n);
    rst_n = 1'b0;
    #1;
    check("rst_mid_write", ym_write, 1'b0);
    check("rst_mid_level", level, 3'd0);
    check("rst_mid_idle", idle, 1'b1);
    check("rst_mid_ready", cmd_ready, 1'b1);
    check("rst_mid_err", timeout_err, 1'b0);
    base_a = n_addr;
    base_d = n_data;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_no_addr", n_addr - base_a, 0);
    check("rst_no_data", n_data - base_d, 0);
    check("rst_after_idle", idle, 1'b1);

    // Random stream through the receive model.
    base_a = n_addr;
    base_d = n_data;
    for (int i = 0; i < 500; i++) begin
      busy_len = $urandom_range(0, 4);
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle(2000, n);
    check("rand_addr_writes", n_addr - base_a, 500);
    check("rand_data_writes", n_data - base_d, 500);
    check("rand_sb_drained", sb_q.size(), 0);
    check("rand_no_timeout", timeout_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
